pwm_hbridge_multi: RTL and testbench
====================================

// Module: pwm_hbridge_multi
// PURPOSE
//  N-channel H-bridge PWM generator driving motor_positive/motor_negative pairs of the ESC.
//  Accepts signed duty (sign = direction), double-buffers period/duty/dead time, applies updates only at period wrap.
//  Inserts programmable dead time on direction reversal so both legs are never driven together.
//  Sits between the register block (I2C-written settings) and the PID/ESC control path, on the slow PWM clock.
// PARAMETERS
//  CHANNELS  2   number of independent H-bridge channels
//  CNT_W     16  period counter / duty magnitude width
//  DEAD_W    8   dead-time counter width
// PORTS
//  clk             in   1                   PWM clock; sole clock of the block
//  rst             in   1                   asynchronous, active-high reset
//  pwm_en          in   1                   global enable; low = counter parked, outputs low
//  pwm_period      in   CNT_W               period in clk cycles (pending value)
//  duty            in   CHANNELS*(CNT_W+1)  packed signed duty, ch0 at LSBs, two's complement
//  dead_time       in   DEAD_W              dead-time cycles on direction reversal
//  load            in   1                   1-cycle strobe: capture period/duty/dead_time into pending set
//  load_ack        out  1                   1-cycle pulse when pending set becomes active
//  period_start    out  1                   1-cycle pulse in cycle counter==0 while running
//  motor_positive  out  CHANNELS            forward leg drive per channel
//  motor_negative  out  CHANNELS            reverse leg drive per channel
// BEHAVIOUR
//  Reset: counter=0, active/pending regs=0, pending_valid=0, dead counters=0, all outputs 0.
//  Shadowing: load captures inputs into pending regs, sets pending_valid; a later load before commit overwrites.
//  Commit: pending->active when pending_valid and (counter wraps to 0, or pwm_en=0, or active period==0);
//   load_ack pulses the cycle after commit; pending_valid clears. load same cycle as commit: new data goes pending.
//  Counter: running when pwm_en=1 and active period P>0; counts 0..P-1, wraps to 0. P==0 -> counter held 0, outputs 0.
//  pwm_en=0: counter forced 0, outputs 0, dead counters cleared; on pwm_en 0->1 counting starts at 0.
//  Magnitude: mag=|duty|; most-negative value -> 2^CNT_W; mag saturated to P. mag=0 -> both legs low all period.
//  Raw drive: on = (counter < mag); duty>=0 -> motor_positive=on, motor_negative=0; duty<0 -> reverse.
//  Dead time: per channel track last driven sign; at commit where sign changes (zero counts as positive),
//   dead counter loads dead_time; both legs forced 0 while dead counter !=0 (decrements each running cycle).
//   dead_time=0 -> no blanking. Dead blanking longer than P continues across wraps.
//  Latency: outputs registered, 1 clk after counter value they reflect; period_start aligned with first output cycle.
//  Invariant: motor_positive[i] & motor_negative[i] never 1 in any cycle, including reset release and reload.
//  Reset mid-operation: all state cleared asynchronously; outputs go 0 immediately; pending data lost.
// TESTING
//  1. rst, P=100, duty0=+25, load, pwm_en=1 -> motor_positive[0] high 25/100 cycles, negative 0; load_ack once.
//  2. Running P=100 duty=+25; load duty=+60 at counter=40 -> current period stays 25, next period 60, ack at wrap.
//  3. duty +50 -> -50 with dead_time=10, P=100 -> both legs low 10 cycles after wrap, then negative high 40 cycles.
//  4. duty=+150 with P=100 -> positive constantly high; duty=-2^16 -> negative constantly high; P=0 -> all low.
//  5. Assert rst at counter=57 mid-pulse -> outputs 0 same cycle; after release no output until new load+enable.
//  6. CHANNELS=2: ch0=+30, ch1=-70, P=200, random loads/pwm_en toggles -> independent duty; pos&neg never both 1.

Source files
------------

// File: rtl/pwm_hbridge_multi.sv
// Multi-channel H-bridge PWM generator: signed duty per channel, shadowed settings
// committed at period wrap, and dead-time blanking on direction reversal.
module pwm_hbridge_multi #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 16,
  parameter int DEAD_W   = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pwm_en,
  input  logic [CNT_W-1:0]                pwm_period,
  input  logic [CHANNELS*(CNT_W+1)-1:0]   duty,
  input  logic [DEAD_W-1:0]               dead_time,
  input  logic                            load,
  output logic                            load_ack,
  output logic                            period_start,
  output logic [CHANNELS-1:0]             motor_positive,
  output logic [CHANNELS-1:0]             motor_negative
);

  localparam int DW = CNT_W + 1;

  logic [CNT_W-1:0]          pend_period_q, pend_period_d;
  logic [CHANNELS*DW-1:0]    pend_duty_q, pend_duty_d;
  logic [DEAD_W-1:0]         pend_dead_q, pend_dead_d;
  logic                      pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0]          act_period_q, act_period_d;
  logic [CHANNELS*DW-1:0]    act_duty_q, act_duty_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      ack_q, ack_d;
  logic                      ps_q, ps_d;

  logic running;
  logic wrap;
  logic commit;

  assign running = pwm_en && (act_period_q != '0);
  assign wrap    = running && (cnt_q == act_period_q - 1'b1);
  // Pending settings go live at a period boundary, or at once when nothing is being generated.
  assign commit  = pend_valid_q && (!pwm_en || (act_period_q == '0) || wrap);

  always_comb begin
    pend_period_d = pend_period_q;
    pend_duty_d   = pend_duty_q;
    pend_dead_d   = pend_dead_q;
    pend_valid_d  = pend_valid_q;
    act_period_d  = act_period_q;
    act_duty_d    = act_duty_q;
    cnt_d         = '0;
    ack_d         = commit;
    ps_d          = running && (cnt_q == '0);

    if (commit) begin
      act_period_d = pend_period_q;
      act_duty_d   = pend_duty_q;
      pend_valid_d = 1'b0;
    end
    // A load coinciding with a commit lands in the pending set for the next boundary.
    if (load) begin
      pend_period_d = pwm_period;
      pend_duty_d   = duty;
      pend_dead_d   = dead_time;
      pend_valid_d  = 1'b1;
    end

    if (running && !wrap) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_period_q <= '0;
      pend_duty_q   <= '0;
      pend_dead_q   <= '0;
      pend_valid_q  <= 1'b0;
      act_period_q  <= '0;
      act_duty_q    <= '0;
      cnt_q         <= '0;
      ack_q         <= 1'b0;
      ps_q          <= 1'b0;
    end else begin
      pend_period_q <= pend_period_d;
      pend_duty_q   <= pend_duty_d;
      pend_dead_q   <= pend_dead_d;
      pend_valid_q  <= pend_valid_d;
      act_period_q  <= act_period_d;
      act_duty_q    <= act_duty_d;
      cnt_q         <= cnt_d;
      ack_q         <= ack_d;
      ps_q          <= ps_d;
    end
  end

  assign load_ack     = ack_q;
  assign period_start = ps_q;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [DW-1:0]     duty_cur;
      logic [DW-1:0]     duty_new;
      logic              is_neg;
      logic [DW-1:0]     mag;
      logic [DW-1:0]     mag_sat;
      logic              on;
      logic              drive;
      logic              sign_q, sign_d;
      logic [DEAD_W-1:0] dead_q, dead_d;
      logic              pos_q, pos_d;
      logic              neg_q, neg_d;

      assign duty_cur = act_duty_q[gi*DW +: DW];
      assign duty_new = pend_duty_q[gi*DW +: DW];
      assign is_neg   = duty_cur[DW-1];
      // The most-negative code negates to 2^CNT_W, which still fits the widened magnitude.
      assign mag      = is_neg ? (~duty_cur + 1'b1) : duty_cur;
      assign mag_sat  = (mag > {1'b0, act_period_q}) ? {1'b0, act_period_q} : mag;
      assign on       = ({1'b0, cnt_q} < mag_sat);
      assign drive    = running && on && (dead_q == '0);

      always_comb begin
        sign_d = sign_q;
        dead_d = dead_q;
        pos_d  = drive && !is_neg;
        neg_d  = drive && is_neg;
        if (running && (dead_q != '0)) begin
          dead_d = dead_q - 1'b1;
        end
        if (commit) begin
          sign_d = duty_new[DW-1];
          if (duty_new[DW-1] != sign_q) begin
            dead_d = pend_dead_q;
          end
        end
        if (!pwm_en) begin
          dead_d = '0;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sign_q <= 1'b0;
          dead_q <= '0;
          pos_q  <= 1'b0;
          neg_q  <= 1'b0;
        end else begin
          sign_q <= sign_d;
          dead_q <= dead_d;
          pos_q  <= pos_d;
          neg_q  <= neg_d;
        end
      end

      assign motor_positive[gi] = pos_q;
      assign motor_negative[gi] = neg_q;
    end
  endgenerate

endmodule

// File: tb/tb_pwm_hbridge_multi.sv
// Directed bench for pwm_hbridge_multi: duty, shadow commit, dead time, saturation, reset.
module tb_pwm_hbridge_multi;
  localparam int CH  = 2;
  localparam int CW  = 16;
  localparam int DTW = 8;
  localparam int DW  = CW + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              pwm_en;
  logic [CW-1:0]     pwm_period;
  logic [CH*DW-1:0]  duty;
  logic [DTW-1:0]    dead_time;
  logic              load;
  logic              load_ack;
  logic              period_start;
  logic [CH-1:0]     motor_positive;
  logic [CH-1:0]     motor_negative;

  int total = 0;
  int bad   = 0;
  int ack_cnt = 0;
  int viol = 0;
  int m_pos [CH];
  int m_neg [CH];
  int m_first_neg0;

  always #5 clk = ~clk;

  pwm_hbridge_multi #(.CHANNELS(CH), .CNT_W(CW), .DEAD_W(DTW)) dut (
    .clk            (clk),
    .rst            (rst),
    .pwm_en         (pwm_en),
    .pwm_period     (pwm_period),
    .duty           (duty),
    .dead_time      (dead_time),
    .load           (load),
    .load_ack       (load_ack),
    .period_start   (period_start),
    .motor_positive (motor_positive),
    .motor_negative (motor_negative)
  );

  always @(negedge clk) begin
    if (load_ack === 1'b1) ack_cnt++;
    if ((motor_positive & motor_negative) != 2'b00) viol++;
  end

  task automatic do_load(input int p, input int d0, input int d1, input int dt);
    pwm_period = p[CW-1:0];
    duty       = {d1[DW-1:0], d0[DW-1:0]};
    dead_time  = dt[DTW-1:0];
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    while (load_ack !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (load_ack !== 1'b1) begin
      bad++;
      $display("FAIL %s_ack: load_ack=%b after %0d cycles, want 1", name, load_ack, n);
    end
  endtask

  task automatic wait_ps(input string name);
    int n = 0;
    while (period_start !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (period_start !== 1'b1) begin
      bad++;
      $display("FAIL %s_ps: period_start=%b after %0d cycles, want 1", name, period_start, n);
    end
  endtask

  // Counts high cycles per leg over one period starting at period_start.
  task automatic measure(input string name, input int p);
    for (int c = 0; c < CH; c++) begin
      m_pos[c] = 0;
      m_neg[c] = 0;
    end
    m_first_neg0 = -1;
    wait_ps(name);
    for (int i = 0; i < p; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (motor_positive[c] === 1'b1) m_pos[c]++;
        if (motor_negative[c] === 1'b1) m_neg[c]++;
      end
      if (motor_negative[0] === 1'b1 && m_first_neg0 < 0) m_first_neg0 = i;
      @(negedge clk);
    end
  endtask

  task automatic expect_int(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; pwm_en = 1'b0; load = 1'b0;
    pwm_period = '0; duty = '0; dead_time = '0;
    repeat (3) @(negedge clk);
    expect_int("reset_pos", int'(motor_positive), 0);
    expect_int("reset_neg", int'(motor_negative), 0);
    expect_int("reset_ack", int'(load_ack), 0);
    expect_int("reset_ps", int'(period_start), 0);
    rst = 1'b0;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_basic;
    int a0 = ack_cnt;
    do_load(100, 25, 0, 0);
    wait_ack("t1");
    pwm_en = 1'b1;
    measure("t1", 100);
    expect_int("t1_pos0", m_pos[0], 25);
    expect_int("t1_neg0", m_neg[0], 0);
    expect_int("t1_ack_once", ack_cnt - a0, 1);
    $display("test_basic pos0=%0d neg0=%0d", m_pos[0], m_neg[0]);
  endtask

  task automatic test_shadow;
    int a0 = ack_cnt;
    int cnt = 0;
    wait_ps("t2");
    for (int i = 0; i < 100; i++) begin
      if (motor_positive[0] === 1'b1) cnt++;
      if (i == 39) begin
        pwm_period = 16'd100; duty = {17'd0, 17'd60}; dead_time = '0; load = 1'b1;
      end
      if (i == 40) load = 1'b0;
      if (i == 99) expect_int("t2_ack_at_wrap", int'(load_ack), 1);
      @(negedge clk);
    end
    expect_int("t2_cur_period", cnt, 25);
    measure("t2", 100);
    expect_int("t2_next_period", m_pos[0], 60);
    expect_int("t2_ack_once", ack_cnt - a0, 1);
    $display("test_shadow cur=%0d next=%0d", cnt, m_pos[0]);
  endtask

  task automatic test_dead_time;
    do_load(100, 50, 0, 10);
    wait_ack("t3a");
    measure("t3a", 100);
    expect_int("t3_pos50", m_pos[0], 50);
    do_load(100, -50, 0, 10);
    wait_ack("t3b");
    measure("t3b", 100);
    expect_int("t3_rev_pos", m_pos[0], 0);
    expect_int("t3_rev_neg", m_neg[0], 40);
    expect_int("t3_rev_first", m_first_neg0, 10);
    measure("t3c", 100);
    expect_int("t3_steady_neg", m_neg[0], 50);
    $display("test_dead_time neg=%0d first=%0d", m_neg[0], m_first_neg0);
  endtask

  task automatic test_saturation;
    int hi = 0;
    do_load(100, 150, 0, 0);
    wait_ack("t4a");
    measure("t4a", 100);
    expect_int("t4_sat_pos", m_pos[0], 100);
    expect_int("t4_sat_negleg", m_neg[0], 0);
    do_load(100, -65536, 0, 0);
    wait_ack("t4b");
    measure("t4b", 100);
    expect_int("t4_minneg_neg", m_neg[0], 100);
    expect_int("t4_minneg_pos", m_pos[0], 0);
    do_load(0, 0, 0, 0);
    wait_ack("t4c");
    @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      if ((motor_positive | motor_negative) != 2'b00 || period_start === 1'b1) hi++;
      @(negedge clk);
    end
    expect_int("t4_p0_idle", hi, 0);
    $display("test_saturation p0_active_cycles=%0d", hi);
  endtask

  task automatic test_reset_mid;
    int hi = 0;
    do_load(100, 80, 0, 0);
    wait_ack("t5");
    wait_ps("t5");
    repeat (56) @(negedge clk);
    expect_int("t5_mid_pulse", int'(motor_positive[0]), 1);
    #1 rst = 1'b1;
    #1;
    expect_int("t5_async_pos", int'(motor_positive), 0);
    expect_int("t5_async_neg", int'(motor_negative), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 250; i++) begin
      if ((motor_positive | motor_negative) != 2'b00 || period_start === 1'b1 || load_ack === 1'b1) hi++;
      @(negedge clk);
    end
    expect_int("t5_quiet_after", hi, 0);
    do_load(100, 30, 0, 0);
    wait_ack("t5b");
    measure("t5b", 100);
    expect_int("t5_reload_pos", m_pos[0], 30);
    $display("test_reset_mid quiet=%0d reload=%0d", hi, m_pos[0]);
  endtask

  task automatic test_multi;
    do_load(200, 30, -70, 0);
    wait_ack("t6");
    measure("t6", 200);
    expect_int("t6_pos0", m_pos[0], 30);
    expect_int("t6_neg0", m_neg[0], 0);
    expect_int("t6_pos1", m_pos[1], 0);
    expect_int("t6_neg1", m_neg[1], 70);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(39) == 0) pwm_en = ~pwm_en;
      if ($urandom_range(29) == 0) begin
        pwm_period = 16'($urandom_range(60));
        duty = {17'(int'($urandom_range(160)) - 80), 17'(int'($urandom_range(160)) - 80)};
        dead_time = 8'($urandom_range(15));
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    pwm_en = 1'b0;
    repeat (5) @(negedge clk);
    do_load(200, 30, -70, 5);
    wait_ack("t6b");
    pwm_en = 1'b1;
    measure("t6b", 200);
    measure("t6c", 200);
    expect_int("t6_after_pos0", m_pos[0], 30);
    expect_int("t6_after_neg1", m_neg[1], 70);
    expect_int("t6_no_overlap", viol, 0);
    $display("test_multi pos0=%0d neg1=%0d overlap=%0d", m_pos[0], m_neg[1], viol);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shadow();
    test_dead_time();
    test_saturation();
    test_reset_mid();
    test_multi();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
